// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encoding, default baud constants and small helpers.
// Used by the receive block and the transmit side of the system-bus UART link.
package uart_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_t;

  // 50 MHz system clock, 9600 baud, 16x oversampling, 8 data bits.
  localparam int DEFAULT_CLOCKS_PER_PULSE = 5208;
  localparam int DEFAULT_OVERSAMPLE       = 16;
  localparam int DEFAULT_DATA_WIDTH       = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Even parity: returns the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: divides clk by DIV, emits a one-cycle tick and the
// index of that tick within the current bit (0..OVERSAMPLE-1). restart realigns to a start edge.
module uart_rx_tick_gen #(
  parameter int DIV        = 10,
  parameter int OVERSAMPLE = 16,
  localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1,
  localparam int TICK_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              restart,
  output logic              tick,
  output logic [TICK_W-1:0] tick_idx
);

  logic [DIV_W-1:0]  div_r;
  logic [TICK_W-1:0] bit_cnt_r;

  // Clock divider and per-bit tick counter; restart wins over a coincident wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_r     <= {DIV_W{1'b0}};
      bit_cnt_r <= {TICK_W{1'b0}};
      tick      <= 1'b0;
      tick_idx  <= {TICK_W{1'b0}};
    end else if (restart) begin
      div_r     <= {DIV_W{1'b0}};
      bit_cnt_r <= {TICK_W{1'b0}};
      tick      <= 1'b0;
      tick_idx  <= tick_idx;
    end else if (div_r == DIV_W'(DIV - 1)) begin
      div_r     <= {DIV_W{1'b0}};
      tick      <= 1'b1;
      tick_idx  <= bit_cnt_r;
      bit_cnt_r <= (bit_cnt_r == TICK_W'(OVERSAMPLE - 1)) ? {TICK_W{1'b0}}
                                                           : bit_cnt_r + TICK_W'(1);
    end else begin
      div_r     <= div_r + DIV_W'(1);
      tick      <= 1'b0;
      tick_idx  <= tick_idx;
      bit_cnt_r <= bit_cnt_r;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// UART 8N1 receiver with 2-FF synchroniser, mid-bit 3-sample majority vote, glitch rejection,
// framing and break detection. Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_oversampled
  import uart_defs_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
  parameter int OVERSAMPLE       = DEFAULT_OVERSAMPLE,
  parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_err,
  output logic                  break_det
);

  localparam int DIV    = CLOCKS_PER_PULSE / OVERSAMPLE;
  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TICK_W-1:0] SAMP_A = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] SAMP_B = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] SAMP_C = TICK_W'(OVERSAMPLE / 2 + 1);

  logic                  sync1_r, sync2_r, prev_r;
  logic                  start_edge_s;
  logic                  tick_s;
  logic [TICK_W-1:0]     tick_idx_s;
  logic                  samp_a_r, samp_b_r;
  logic                  vote_r, vote_vld_r;
  logic                  parity_err_s;
  uart_state_t           state_r;
  logic [IDX_W-1:0]      bit_idx_r;
  logic [DATA_WIDTH-1:0] shift_r;

  // Two-stage synchroniser plus one history stage for falling-edge detection; idle-high preset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // A start needs a genuine 1->0 edge, so a line already low at reset release is ignored.
  assign start_edge_s = (state_r == ST_IDLE) & prev_r & ~sync2_r;

  uart_rx_tick_gen #(
    .DIV        (DIV),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_gen (
    .clk      (clk),
    .rstn     (rstn),
    .restart  (start_edge_s),
    .tick     (tick_s),
    .tick_idx (tick_idx_s)
  );

  // Mid-bit sampling: two early samples held, vote formed on the third tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      samp_a_r   <= 1'b1;
      samp_b_r   <= 1'b1;
      vote_r     <= 1'b1;
      vote_vld_r <= 1'b0;
    end else if (start_edge_s) begin
      vote_vld_r <= 1'b0;
    end else if (tick_s && (tick_idx_s == SAMP_A)) begin
      samp_a_r   <= sync2_r;
      vote_vld_r <= 1'b0;
    end else if (tick_s && (tick_idx_s == SAMP_B)) begin
      samp_b_r   <= sync2_r;
      vote_vld_r <= 1'b0;
    end else if (tick_s && (tick_idx_s == SAMP_C)) begin
      vote_r     <= majority3(samp_a_r, samp_b_r, sync2_r);
      vote_vld_r <= 1'b1;
    end else begin
      vote_vld_r <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_r;

  // Parity mismatch latched when the parity bit is voted, consumed in STOP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity_err_r <= 1'b0;
    end else if (state_r == ST_PARITY && vote_vld_r) begin
      parity_err_r <= vote_r ^ even_parity(32'(shift_r));
    end else if (start_edge_s) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= parity_err_r;
    end
  end

  assign parity_err_s = parity_err_r;
`else
  assign parity_err_s = 1'b0;
`endif

  // Frame FSM with registered ready / frame_err pulses and break level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      bit_idx_r <= {IDX_W{1'b0}};
      shift_r   <= {DATA_WIDTH{1'b0}};
      data_out  <= {DATA_WIDTH{1'b0}};
      ready     <= 1'b0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      ready     <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            state_r   <= ST_START;
            bit_idx_r <= {IDX_W{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          if (vote_vld_r) begin
            state_r   <= vote_r ? ST_IDLE : ST_DATA;
            bit_idx_r <= {IDX_W{1'b0}};
          end else begin
            state_r <= ST_START;
          end
        end
        ST_DATA: begin
          if (vote_vld_r) begin
            shift_r <= {vote_r, shift_r[DATA_WIDTH-1:1]};
            if (bit_idx_r == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + IDX_W'(1);
            end
          end else begin
            state_r <= ST_DATA;
          end
        end
        ST_PARITY: begin
          state_r <= vote_vld_r ? ST_STOP : ST_PARITY;
        end
        ST_STOP: begin
          if (vote_vld_r) begin
            if (vote_r && !parity_err_s) begin
              data_out <= shift_r;
              ready    <= 1'b1;
              state_r  <= ST_IDLE;
            end else if (vote_r) begin
              frame_err <= 1'b1;
              state_r   <= ST_IDLE;
            end else if (shift_r == {DATA_WIDTH{1'b0}}) begin
              frame_err <= 1'b1;
              break_det <= 1'b1;
              state_r   <= ST_BREAK;
            end else begin
              frame_err <= 1'b1;
              state_r   <= ST_IDLE;
            end
          end else begin
            state_r <= ST_STOP;
          end
        end
        ST_BREAK: begin
          if (sync2_r) begin
            break_det <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r <= ST_BREAK;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames push expected events,
// an independent monitor pops and compares on every ready / frame_err pulse.
module tb_uart_rx_oversampled;

  localparam int CPP = 160;
  localparam int OS  = 16;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rx = 1'b1;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          frame_err;
  logic          break_det;

  always #5 clk = ~clk;

  uart_rx_oversampled #(
    .CLOCKS_PER_PULSE (CPP),
    .OVERSAMPLE       (OS),
    .DATA_WIDTH       (DW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .ready     (ready),
    .data_out  (data_out),
    .frame_err (frame_err),
    .break_det (break_det)
  );

  typedef struct {
    logic          is_err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_ok(input logic [DW-1:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
    last_good = d;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    exp_q.push_back(e);
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPP) @(posedge clk);
  endtask

  // Start bit, LSB-first data, optional parity (flip=1 corrupts it), stop bit; line left at stop.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic par_flip);
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < DW; i++) begin
      rx = d[i];
      wait_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_bits(1);
`else
    if (par_flip) $display("note: parity flip ignored without parity");
`endif
    rx = stop;
    wait_bits(1);
  endtask

  // Monitor: every output event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (ready || frame_err) begin
      if (exp_q.size() == 0) begin
        check("spurious_event", {30'd0, frame_err, ready}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {30'd0, frame_err, ready}, e.is_err ? 32'd2 : 32'd1);
        check("data_out", 32'(data_out), 32'(e.data));
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    rx   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_break_det", 32'(break_det), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    @(negedge clk) rstn = 1'b1;
    wait_bits(2);

    // Plain good frame
    expect_ok(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    rx = 1'b1;
    wait_bits(2);

    // Short low glitch must be rejected silently
    rx = 1'b0;
    repeat (40) @(posedge clk);
    rx = 1'b1;
    wait_bits(2);

    // Bad stop bit: frame error, data_out keeps 0xA5
    expect_err();
    send_frame(8'h5A, 1'b0, 1'b0);
    rx = 1'b1;
    wait_bits(2);
    check("hold_after_ferr", 32'(data_out), 32'hA5);

    // Back-to-back frames, no idle gap
    expect_ok(8'h00);
    send_frame(8'h00, 1'b1, 1'b0);
    expect_ok(8'hFF);
    send_frame(8'hFF, 1'b1, 1'b0);
    expect_ok(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_bits(2);
    check("b2b_last", 32'(data_out), 32'h3C);

    // Break: line low 12 bit times
    expect_err();
    rx = 1'b0;
    wait_bits(11);
    check("break_high", 32'(break_det), 32'd1);
    wait_bits(1);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("break_cleared", 32'(break_det), 32'd0);
    wait_bits(1);
    expect_ok(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    rx = 1'b1;
    wait_bits(2);

    // Reset in the middle of the data bits of 0x77
    rx = 1'b0;
    wait_bits(1);
    rx = 1'b1;
    wait_bits(3);
    rx = 1'b0;
    repeat (CPP / 2) @(posedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_break", 32'(break_det), 32'd0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    last_good = 8'h00;
    wait_bits(2);
    check("post_rst_data_out", 32'(data_out), 32'd0);
    expect_ok(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    rx = 1'b1;
    wait_bits(2);
    check("post_rst_frame", 32'(data_out), 32'h12);

`ifdef UART_RX_PARITY_EN
    expect_err();
    send_frame(8'h03, 1'b1, 1'b1);
    rx = 1'b1;
    wait_bits(2);
    expect_ok(8'h03);
    send_frame(8'h03, 1'b1, 1'b0);
    rx = 1'b1;
    wait_bits(2);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
